// File: rtl/uio_arb_pkg.sv
// Shared codes for the uio pad-bus arbiter: FSM state values and requester direction encoding.
// Latency: none, constants only.
// Backpressure: none, constants only.
package uio_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DRIVE   = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    localparam logic DIR_DRIVE   = 1'b1;
    localparam logic DIR_CAPTURE = 1'b0;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the first set request scanning upward from (ptr+1) mod NREQ.
// Latency: purely combinational.
// Backpressure: none; valid low when no request is set.
// Ports: req (request vector), ptr (last owner), pick (one-hot winner), valid (any winner).
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         pick,
    output logic                    valid
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        // Offset 1 first, so the previous owner is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the bidirectional uio pad bus between NREQ drive/capture requesters.
// Latency: req before edge t0 -> gnt from t0+1 -> first beat (ack) at t0+1+TURN; rdata/rvalid one cycle after a capture beat.
// Backpressure: ack is the per-beat handshake; a grant ends when the owner drops req, flips dir, or hits MAX_HOLD beats.
// Ports: clk/rst; req/dir/wdata from requesters; gnt/ack/rdata/rvalid back to them; pad_in/pad_out/pad_oe to the uio pads.
module uio_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              ack,
    output logic [W-1:0]      rdata,
    output logic              rvalid,
    input  logic [W-1:0]      pad_in,
    output logic [W-1:0]      pad_out,
    output logic [W-1:0]      pad_oe
);

    import uio_arb_pkg::*;

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TURN + 1);
    localparam int BW = $clog2(MAX_HOLD + 1);

    logic [1:0]      state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   pick_idx;
    logic            ldir;
    logic [TW-1:0]   turn_cnt;
    logic [BW-1:0]   beat_cnt;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic            xfer;
    logic            beat;

    rr_picker #(
        .NREQ (NREQ)
    ) u_rr_picker (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // A cycle in DRIVE/CAPTURE is only a beat while the owner still asks in the
    // latched direction; otherwise it is the closing cycle and carries no ack.
    assign xfer    = (state == ST_DRIVE) || (state == ST_CAPTURE);
    assign beat    = xfer && req[owner] && (dir[owner] == ldir);
    assign ack     = beat;
    assign pad_oe  = {W{state == ST_DRIVE}};
    assign pad_out = (state == ST_DRIVE) ? wdata[int'(owner)*W +: W] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner    <= '0;
            ldir     <= 1'b0;
            ptr      <= PW'(NREQ - 1);
            turn_cnt <= '0;
            beat_cnt <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state    <= ST_RELEASE;
                        gnt      <= pick;
                        owner    <= pick_idx;
                        ldir     <= dir[pick_idx];
                        turn_cnt <= TW'(TURN - 1);
                    end
                end
                ST_RELEASE: begin
                    if (!req[owner]) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        ptr   <= owner;
                    end else if (turn_cnt == '0) begin
                        state    <= (ldir == DIR_DRIVE) ? ST_DRIVE : ST_CAPTURE;
                        beat_cnt <= '0;
                    end else begin
                        turn_cnt <= turn_cnt - TW'(1);
                    end
                end
                ST_DRIVE, ST_CAPTURE: begin
                    if (!beat) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        ptr   <= owner;
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (ldir == DIR_CAPTURE) begin
                            rdata  <= pad_in;
                            rvalid <= 1'b1;
                        end
                        // Last allowed beat: leave directly so the counter never passes MAX_HOLD.
                        if (beat_cnt == BW'(MAX_HOLD - 1)) begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                            ptr   <= owner;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: requester agents issue beat jobs, a monitor scores every beat.
// Latency: n/a.
// Backpressure: agents hold req until each queued beat is acked, then drop it.
module tb_uio_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int W        = 8;
    localparam int TURN     = 1;
    localparam int MAX_HOLD = 4;
    localparam logic DRV    = 1'b1;
    localparam logic CAP    = 1'b0;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   dir;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic              ack;
    logic [W-1:0]      rdata;
    logic              rvalid;
    logic [W-1:0]      pad_in;
    logic [W-1:0]      pad_out;
    logic [W-1:0]      pad_oe;

    uio_bus_arbiter #(
        .NREQ(NREQ), .W(W), .TURN(TURN), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .dir(dir), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .rvalid(rvalid),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe)
    );

    always #5 clk = ~clk;

    // Scoreboard: exp_q holds {dir, data} per beat still owed to each requester;
    // stim_q is the agent's own copy used to drive wdata; rd_q holds capture values due on rvalid.
    logic [W:0]      exp_q  [NREQ][$];
    logic [W-1:0]    stim_q [NREQ][$];
    logic [W-1:0]    rd_q[$];
    logic [NREQ-1:0] jdir;
    bit              mon_en;
    bit              pad_rand;
    logic            s_ack;
    logic [NREQ-1:0] s_gnt;
    logic [W-1:0]    s_oe;
    int              n_checks = 0;
    int              n_pass   = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
    endfunction

    // Next owner by round-robin rule: first requester above the last owner, wrapping.
    function automatic int rr_next(logic [NREQ-1:0] r, int last);
        int j;
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            if (((r >> j) & NREQ'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic job(int i, logic d, int n, logic [W-1:0] v, bit rnd);
        jdir[i] = d;
        for (int k = 0; k < n; k++) begin
            logic [W-1:0] x;
            x = rnd ? W'($urandom) : v + W'(k);
            stim_q[i].push_back(x);
            exp_q[i].push_back({d, x});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]           = (stim_q[i].size() > 0);
            dir[i]           = jdir[i];
            wdata[i*W +: W]  = (stim_q[i].size() > 0) ? stim_q[i][0] : '0;
        end
        pad_in = pad_rand ? W'($urandom) : 8'h3C;
    endtask

    // Sample outputs mid-cycle, then retire acked beats just after the next edge.
    task automatic cycle();
        @(negedge clk);
        s_ack = ack;
        s_gnt = gnt;
        s_oe  = pad_oe;
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (s_ack && s_gnt[i] && stim_q[i].size() > 0) stim_q[i].delete(0);
        end
    endtask

    task automatic drain();
        int  quiet;
        int  k;
        int  owed;
        bit  busy;
        quiet = 0;
        k     = 0;
        drive();
        while (quiet < 3 && k < 400) begin
            cycle();
            drive();
            k++;
            busy = (s_gnt != '0);
            for (int i = 0; i < NREQ; i++) if (stim_q[i].size() > 0) busy = 1'b1;
            quiet = busy ? 0 : quiet + 1;
        end
        check("drain_done", 32'(quiet >= 3), 32'd1);
        owed = 0;
        for (int i = 0; i < NREQ; i++) owed += exp_q[i].size();
        check("beats_outstanding", 32'(owed), 32'd0);
    endtask

    // Monitor: grant order, release phase, beat contents, rvalid/rdata timing.
    initial begin : monitor
        logic [NREQ-1:0] prev_req;
        logic [NREQ-1:0] prev_dir;
        logic [NREQ-1:0] prev_gnt;
        logic [NREQ-1:0] exp_gnt;
        logic [W:0]      e;
        logic [W-1:0]    rv;
        int              last_owner;
        int              owner;
        int              since;
        int              beats;
        int              nxt;
        logic            lat_dir;
        prev_req   = '0;
        prev_dir   = '0;
        prev_gnt   = '0;
        last_owner = NREQ - 1;
        owner      = 0;
        since      = 0;
        beats      = 0;
        lat_dir    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                last_owner = NREQ - 1;
                prev_gnt   = '0;
                rd_q.delete();
            end else begin
                if (rd_q.size() > 0) begin
                    rv = rd_q.pop_front();
                    check("rvalid_after_capture", 32'(rvalid), 32'd1);
                    check("rdata", 32'(rdata), 32'(rv));
                end else begin
                    check("rvalid_quiet", 32'(rvalid), 32'd0);
                end
                check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
                check("pad_oe_all_or_none", 32'((pad_oe == '0) || (pad_oe == '1)), 32'd1);

                if (prev_gnt == '0 && gnt != '0) begin
                    nxt     = rr_next(prev_req, last_owner);
                    exp_gnt = (nxt < 0) ? '0 : (NREQ'(1) << nxt);
                    check("rr_grant", 32'(gnt), 32'(exp_gnt));
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            owner   = i;
                            lat_dir = prev_dir[i];
                        end
                    end
                    since = 0;
                    beats = 0;
                    check("pad_oe_in_release", 32'(pad_oe), 32'd0);
                end else if (prev_gnt != '0 && gnt != '0) begin
                    check("gnt_held", 32'(gnt), 32'(prev_gnt));
                end else if (prev_gnt != '0 && gnt == '0) begin
                    last_owner = owner;
                    check("beats_per_grant_le_max", 32'(beats <= MAX_HOLD), 32'd1);
                end

                if (pad_oe != '0) check("pad_oe_only_drive_grant", 32'((gnt != '0) && lat_dir), 32'd1);

                if (ack) begin
                    check("ack_has_grant", 32'(gnt != '0), 32'd1);
                    if (beats == 0) check("first_beat_latency", 32'(since), 32'(TURN));
                    beats++;
                    check("beat_expected", 32'(exp_q[owner].size() > 0), 32'd1);
                    if (exp_q[owner].size() > 0) begin
                        e = exp_q[owner].pop_front();
                        check("beat_dir", 32'(lat_dir), 32'(e[W]));
                        if (e[W]) begin
                            check("pad_out", 32'(pad_out), 32'(e[W-1:0]));
                            check("pad_oe_drive", 32'(pad_oe), 32'hFF);
                        end else begin
                            check("pad_oe_capture", 32'(pad_oe), 32'd0);
                            rd_q.push_back(pad_in);
                        end
                    end
                end
                if (gnt != '0) since++;
                prev_gnt = gnt;
            end
            prev_req = req;
            prev_dir = dir;
        end
    end

    initial begin : stim
        bit found;
        rst      = 1'b0;
        req      = '0;
        dir      = '0;
        wdata    = '0;
        pad_in   = '0;
        jdir     = '0;
        mon_en   = 1'b0;
        pad_rand = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_pad_oe", 32'(pad_oe), 32'd0);
        check("rst_pad_out", 32'(pad_out), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single drive, three beats from requester 0.
        job(0, DRV, 3, 8'hA5, 1'b0);
        drain();
        // Single capture on requester 2 with a fixed pad value.
        pad_rand = 1'b0;
        job(2, CAP, 1, 8'h00, 1'b1);
        drain();
        pad_rand = 1'b1;
        // All four at once, one beat each, then requester 0 again.
        for (int i = 0; i < NREQ; i++) job(i, DRV, 1, 8'h00, 1'b1);
        drain();
        job(0, DRV, 1, 8'h00, 1'b1);
        drain();
        // Long request hits MAX_HOLD; requester 2 slips in before it resumes.
        job(1, DRV, 6, 8'h10, 1'b0);
        job(2, DRV, 1, 8'h00, 1'b1);
        drain();
        // Requester 3 pulses req for one cycle, so its grant dies in RELEASE.
        req[3] = 1'b1;
        dir[3] = DRV;
        cycle();
        job(0, DRV, 1, 8'h00, 1'b1);
        drain();

        // Random traffic with mixed directions, lengths and aborts.
        for (int c = 0; c < 1500; c++) begin
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (stim_q[i].size() > 0 && $urandom_range(0, 39) == 0) begin
                    stim_q[i].delete();
                    exp_q[i].delete();
                end else if (stim_q[i].size() == 0 && $urandom_range(0, 5) == 0) begin
                    job(i, 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), 8'h00, 1'b1);
                end
            end
            drive();
        end
        drain();

        // Asynchronous reset in the middle of a drive grant.
        job(1, DRV, 6, 8'h40, 1'b0);
        drive();
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            cycle();
            drive();
            found = (s_oe == '1);
        end
        check("reached_drive_before_reset", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_pad_oe", 32'(pad_oe), 32'd0);
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            stim_q[i].delete();
            exp_q[i].delete();
        end
        req = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        // Requester 0 must win over 2 after reset.
        job(2, DRV, 1, 8'h00, 1'b1);
        job(0, DRV, 2, 8'h00, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
